// File: rtl/alu_mc_if.sv
// alu_mc_if: request/response handshake bundle between register-read, ALU and writeback
// Ports (signals):
//   in_valid/in_ready         request handshake (master -> ALU / ALU -> master)
//   op_i, rs_i, rt_i          opcode, operand A, operand B
//   out_valid/out_ready       result handshake (ALU -> consumer / consumer -> ALU)
//   result_o, zero_o, carry_o, ovf_o, neg_o, err_o   result and flags
interface alu_mc_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op_i;
  logic [WIDTH-1:0] rs_i;
  logic [WIDTH-1:0] rt_i;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result_o;
  logic             zero_o;
  logic             carry_o;
  logic             ovf_o;
  logic             neg_o;
  logic             err_o;
  modport master (
    output in_valid, op_i, rs_i, rt_i, out_ready,
    input  in_ready, out_valid, result_o, zero_o, carry_o, ovf_o, neg_o, err_o
  );
  modport slave (
    input  in_valid, op_i, rs_i, rt_i, out_ready,
    output in_ready, out_valid, result_o, zero_o, carry_o, ovf_o, neg_o, err_o
  );
endinterface

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready handshakes and an iterative shift-add multiplier
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   bus    alu_mc_if.slave: request (in_valid/in_ready/op_i/rs_i/rt_i) and
//          registered response (out_valid/out_ready/result_o and flags)
module alu_mc #(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input logic   clk,
  input logic   reset,
  alu_mc_if.slave bus
);
  localparam int SH = $clog2(WIDTH);
  localparam int M  = WIDTH - 1;
  typedef enum logic {IDLE, MUL} state_t;
  state_t             r_state;
  logic [SH-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic               r_valid, r_zero, r_carry, r_ovf, r_neg, r_err;
  logic [WIDTH-1:0]   r_res;
  logic               w_accept, w_is_mul, w_mul_done;
  logic [WIDTH:0]     w_add, w_sub, w_step;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_res;
  logic               w_carry, w_ovf, w_err;
  assign bus.in_ready  = (r_state == IDLE) && (!r_valid || bus.out_ready) && !reset;
  assign bus.out_valid = r_valid;
  assign bus.result_o  = r_res;
  assign bus.zero_o    = r_zero;
  assign bus.carry_o   = r_carry;
  assign bus.ovf_o     = r_ovf;
  assign bus.neg_o     = r_neg;
  assign bus.err_o     = r_err;
  assign w_accept   = bus.in_valid && bus.in_ready;
  assign w_is_mul   = (bus.op_i == 3'd7) && MUL_EN;
  assign w_mul_done = (r_state == MUL) && (r_cnt == SH'(WIDTH - 1));
  assign w_add      = {1'b0, bus.rs_i} + {1'b0, bus.rt_i};
  // bit WIDTH of the extended difference is the unsigned borrow
  assign w_sub      = {1'b0, bus.rs_i} - {1'b0, bus.rt_i};
  // accumulator low half starts as the multiplier; each step adds the
  // multiplicand into the high half on its LSB and shifts right with carry
  assign w_step     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
  assign w_prod     = {w_step, r_acc[WIDTH-1:1]};
  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    w_err   = 1'b0;
    case (bus.op_i)
      3'd0: w_res = bus.rs_i | bus.rt_i;
      3'd1: w_res = bus.rs_i & bus.rt_i;
      3'd2: begin
        w_res   = w_add[M:0];
        w_carry = w_add[WIDTH];
        w_ovf   = (bus.rs_i[M] == bus.rt_i[M]) && (w_add[M] != bus.rs_i[M]);
      end
      3'd3: begin
        w_res   = w_sub[M:0];
        w_carry = w_sub[WIDTH];
        w_ovf   = (bus.rs_i[M] != bus.rt_i[M]) && (w_sub[M] != bus.rs_i[M]);
      end
      3'd4: w_res = bus.rs_i ^ bus.rt_i;
      3'd5: w_res = bus.rs_i << bus.rt_i[SH-1:0];
      3'd6: w_res = bus.rs_i >> bus.rt_i[SH-1:0];
      // only reached by MUL when the multiplier is not built in
      default: w_err = 1'b1;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_mcand <= '0;
      r_acc   <= '0;
      r_valid <= 1'b0;
      r_res   <= '0;
      r_zero  <= 1'b0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
      r_neg   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept && w_is_mul) begin
        r_state <= MUL;
        r_cnt   <= '0;
        r_mcand <= bus.rs_i;
        r_acc   <= {{WIDTH{1'b0}}, bus.rt_i};
      end else if (r_state == MUL) begin
        r_acc   <= w_prod;
        r_cnt   <= r_cnt + 1'b1;
        r_state <= w_mul_done ? IDLE : MUL;
      end
      if (w_mul_done) begin
        r_valid <= 1'b1;
        r_res   <= w_prod[M:0];
        r_zero  <= ~|w_prod[M:0];
        r_carry <= 1'b0;
        r_ovf   <= |w_prod[2*WIDTH-1:WIDTH];
        r_neg   <= w_prod[M];
        r_err   <= 1'b0;
      end else if (w_accept && !w_is_mul) begin
        r_valid <= 1'b1;
        r_res   <= w_res;
        r_zero  <= ~|w_res;
        r_carry <= w_carry;
        r_ovf   <= w_ovf;
        r_neg   <= w_res[M];
        r_err   <= w_err;
      end else if (r_valid && bus.out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end
endmodule
